// File: rtl/shift_seq_if.sv
// Command and shift-register control bundle between an issuer and shift_seq.
// The master side offers commands; the slave side drives the register mode pins.
interface shift_seq_if #(
    parameter int CW = 3
);
    logic          cmd_valid;
    logic          cmd_ready;
    logic [2:0]    cmd_op;
    logic [CW-1:0] cmd_cnt;
    logic [3:0]    cmd_data;
    logic          cmd_fill;
    logic          abort;
    logic [2:0]    set;
    logic [3:0]    pl;
    logic          sl;
    logic          sr;
    logic          clear;
    logic          busy;
    logic          done;
    logic          err;

    modport master (
        output cmd_valid, cmd_op, cmd_cnt, cmd_data, cmd_fill, abort,
        input  cmd_ready, set, pl, sl, sr, clear, busy, done, err
    );

    modport slave (
        input  cmd_valid, cmd_op, cmd_cnt, cmd_data, cmd_fill, abort,
        output cmd_ready, set, pl, sl, sr, clear, busy, done, err
    );
endinterface

// File: rtl/shift_seq.sv
// Sequencer that turns clear/load/N-step shift commands into cycle-by-cycle
// mode drives for a 4-bit universal shift register.
module shift_seq #(
    parameter int CW = 3
) (
    input  logic       clk,
    input  logic       rst_n,
    shift_seq_if.slave bus
);
    typedef enum logic [1:0] {S_IDLE, S_EXEC, S_DONE} state_t;

    localparam logic [2:0] OP_CLR = 3'b000;
    localparam logic [2:0] OP_SHL = 3'b001;
    localparam logic [2:0] OP_SHR = 3'b010;
    localparam logic [2:0] OP_ASR = 3'b011;
    localparam logic [2:0] OP_LD  = 3'b100;

    state_t        r_state;
    state_t        w_next;
    logic          r_ready;
    logic [2:0]    r_op;
    logic [CW-1:0] r_cnt;
    logic          r_fill;
    logic [3:0]    r_pl;
    logic          w_accept;
    logic          w_is_shift;
    logic          w_rsvd_in;
    logic          w_exec_last;

    assign w_accept    = bus.cmd_valid && r_ready;
    assign w_is_shift  = (bus.cmd_op == OP_SHL) || (bus.cmd_op == OP_SHR) || (bus.cmd_op == OP_ASR);
    assign w_rsvd_in   = bus.cmd_op[2] && (bus.cmd_op[1:0] != 2'b00);
    // Clear/load run one cycle; shifts stop on the last count or on abort.
    assign w_exec_last = bus.abort || (r_op == OP_CLR) || (r_op == OP_LD) || (r_cnt == CW'(1));

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            r_state <= S_IDLE;
            r_ready <= 1'b0;
            r_pl    <= 4'b0000;
        end else begin
            r_state <= w_next;
            r_ready <= (w_next == S_IDLE);
            if (w_accept && (bus.cmd_op == OP_LD)) begin
                r_pl <= bus.cmd_data;
            end
        end
    end

    always_ff @(posedge clk) begin
        if (w_accept) begin
            r_op   <= bus.cmd_op;
            r_cnt  <= bus.cmd_cnt;
            r_fill <= bus.cmd_fill;
        end else if (r_state == S_EXEC) begin
            r_cnt  <= r_cnt - CW'(1);
        end
    end

    always_comb begin
        w_next = r_state;
        unique case (r_state)
            S_IDLE: begin
                if (w_accept) begin
                    if ((w_is_shift && (bus.cmd_cnt == '0)) || w_rsvd_in) begin
                        w_next = S_DONE;
                    end else begin
                        w_next = S_EXEC;
                    end
                end
            end
            S_EXEC:  if (w_exec_last) w_next = S_DONE;
            S_DONE:  w_next = S_IDLE;
            default: w_next = S_IDLE;
        endcase
    end

    always_comb begin
        bus.set   = 3'b000;
        bus.clear = 1'b0;
        bus.sl    = 1'b0;
        bus.sr    = 1'b0;
        bus.busy  = 1'b0;
        bus.done  = 1'b0;
        bus.err   = 1'b0;
        unique case (r_state)
            S_EXEC: begin
                bus.busy = 1'b1;
                if (r_op == OP_CLR) begin
                    bus.clear = 1'b1;
                end else begin
                    bus.set = r_op;
                end
                bus.sl = (r_op == OP_SHL) && r_fill;
                bus.sr = (r_op == OP_SHR) && r_fill;
            end
            S_DONE: begin
                bus.busy = 1'b1;
                bus.done = 1'b1;
                bus.err  = r_op[2] && (r_op[1:0] != 2'b00);
            end
            default: begin
            end
        endcase
    end

    assign bus.pl        = r_pl;
    assign bus.cmd_ready = r_ready;
endmodule

// File: tb/tb_shift_seq.sv
// Bench for shift_seq driving a behavioural 4-bit universal shift register;
// expected outcomes are queued at issue time and compared on each done pulse.
module tb_shift_seq;
    localparam int CW = 3;

    typedef struct {
        logic [3:0] q;
        logic       err;
        int         lat;
        logic [2:0] set;
        int         steps;
        int         clr;
    } exp_t;

    logic clk   = 1'b0;
    logic rst_n = 1'b0;
    logic [3:0] q = 4'b0000;
    int n_chk = 0;
    int n_err = 0;
    exp_t sb[$];

    shift_seq_if #(.CW(CW)) bus ();

    shift_seq #(.CW(CW)) dut (
        .clk  (clk),
        .rst_n(rst_n),
        .bus  (bus)
    );

    always #5 clk = ~clk;

    // Downstream universal shift register
    always @(posedge clk) begin
        if (bus.clear) begin
            q <= 4'b0000;
        end else begin
            case (bus.set)
                3'b001:  q <= {q[2:0], bus.sl};
                3'b010:  q <= {bus.sr, q[3:1]};
                3'b011:  q <= {q[3], q[3:1]};
                3'b100:  q <= bus.pl;
                default: q <= q;
            endcase
        end
    end

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_chk++;
        assert (obs === exp) else begin
            n_err++;
            $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    function automatic exp_t mk(input logic [3:0] q_, input logic err_, input int lat_,
                                input logic [2:0] set_, input int steps_, input int clr_);
        exp_t r;
        r.q     = q_;
        r.err   = err_;
        r.lat   = lat_;
        r.set   = set_;
        r.steps = steps_;
        r.clr   = clr_;
        return r;
    endfunction

    task automatic issue(input logic [2:0] op, input logic [CW-1:0] cnt, input logic [3:0] data,
                         input logic fill, input bit hold, input bit push, input exp_t e);
        int w;
        w = 0;
        bus.cmd_op    = op;
        bus.cmd_cnt   = cnt;
        bus.cmd_data  = data;
        bus.cmd_fill  = fill;
        bus.cmd_valid = 1'b1;
        while (bus.cmd_ready !== 1'b1 && w < 50) begin
            @(negedge clk);
            w++;
        end
        if (w >= 50) chk("accept_timeout", 32'd0, 32'd1);
        if (push) sb.push_back(e);
        @(posedge clk);
        #1;
        if (!hold) bus.cmd_valid = 1'b0;
    endtask

    task automatic wait_done(input string tag, input int abort_at);
        exp_t e;
        int lat, steps, other, clr, rbad, bbad;
        logic errv;
        logic [3:0] qv;
        lat = -1; steps = 0; other = 0; clr = 0; rbad = 0; bbad = 0;
        errv = 1'b0; qv = 4'b0000;
        if (sb.size() == 0) begin
            chk({tag, "_sb_empty"}, 32'd0, 32'd1);
            return;
        end
        e = sb.pop_front();
        for (int k = 1; k <= 20; k++) begin
            @(negedge clk);
            bus.abort = (k == abort_at);
            if (bus.set !== 3'b000) begin
                if (bus.set === e.set) steps++;
                else other++;
            end
            if (bus.clear === 1'b1) clr++;
            if (bus.cmd_ready !== 1'b0) rbad++;
            if (bus.busy !== 1'b1) bbad++;
            if (bus.done === 1'b1) begin
                lat  = k;
                errv = bus.err;
                qv   = q;
                break;
            end
        end
        bus.abort = 1'b0;
        chk({tag, "_latency"}, lat, e.lat);
        chk({tag, "_q"}, {28'd0, qv}, {28'd0, e.q});
        chk({tag, "_err"}, {31'd0, errv}, {31'd0, e.err});
        chk({tag, "_steps"}, steps, e.steps);
        chk({tag, "_stray_set"}, other, 0);
        chk({tag, "_clear_cycles"}, clr, e.clr);
        chk({tag, "_ready_low_busy_high"}, rbad + bbad, 0);
        @(negedge clk);
        chk({tag, "_after_done"}, {28'd0, bus.done, bus.busy, bus.cmd_ready, bus.err}, 32'b0010);
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish, observed timeout expected finish");
        $fatal(1);
    end

    initial begin
        exp_t nx;
        nx = mk(4'b0000, 1'b0, 0, 3'b000, 0, 0);
        bus.cmd_valid = 1'b0;
        bus.cmd_op    = 3'b000;
        bus.cmd_cnt   = '0;
        bus.cmd_data  = 4'b0000;
        bus.cmd_fill  = 1'b0;
        bus.abort     = 1'b0;
        rst_n         = 1'b0;
        repeat (3) @(negedge clk);
        chk("reset_outputs", {18'd0, bus.set, bus.pl, bus.sl, bus.sr, bus.clear, bus.busy,
            bus.done, bus.err, bus.cmd_ready}, 32'd0);
        rst_n = 1'b1;
        @(negedge clk);
        chk("ready_after_reset", {31'd0, bus.cmd_ready}, 32'd1);

        bus.abort = 1'b1;
        @(negedge clk);
        bus.abort = 1'b0;
        chk("abort_idle_ignored", {27'd0, bus.busy, bus.done, bus.set}, 32'd0);

        issue(3'b100, 3'd0, 4'b1011, 1'b0, 0, 1, mk(4'b1011, 1'b0, 2, 3'b100, 1, 0));
        wait_done("load1011", 0);
        issue(3'b001, 3'd2, 4'b0000, 1'b0, 0, 1, mk(4'b1100, 1'b0, 3, 3'b001, 2, 0));
        wait_done("shl2", 0);

        issue(3'b100, 3'd0, 4'b1000, 1'b0, 0, 1, mk(4'b1000, 1'b0, 2, 3'b100, 1, 0));
        wait_done("load1000", 0);
        issue(3'b011, 3'd2, 4'b0000, 1'b0, 0, 1, mk(4'b1110, 1'b0, 3, 3'b011, 2, 0));
        wait_done("asr2", 0);

        issue(3'b000, 3'd0, 4'b0000, 1'b0, 0, 1, mk(4'b0000, 1'b0, 2, 3'b000, 0, 1));
        wait_done("clear1", 0);

        // Second command stays offered for the whole 7-step shift
        issue(3'b010, 3'd7, 4'b0000, 1'b1, 1, 1, mk(4'b1111, 1'b0, 8, 3'b010, 7, 0));
        bus.cmd_op   = 3'b001;
        bus.cmd_cnt  = 3'd1;
        bus.cmd_fill = 1'b0;
        wait_done("shr7_held", 0);
        issue(3'b001, 3'd1, 4'b0000, 1'b0, 0, 1, mk(4'b1110, 1'b0, 2, 3'b001, 1, 0));
        wait_done("shl1_after_hold", 0);

        issue(3'b000, 3'd0, 4'b0000, 1'b0, 0, 1, mk(4'b0000, 1'b0, 2, 3'b000, 0, 1));
        wait_done("clear2", 0);
        issue(3'b001, 3'd5, 4'b0000, 1'b1, 0, 1, mk(4'b0011, 1'b0, 3, 3'b001, 2, 0));
        wait_done("shl5_abort", 2);

        issue(3'b010, 3'd0, 4'b0000, 1'b1, 0, 1, mk(4'b0011, 1'b0, 1, 3'b010, 0, 0));
        wait_done("shr_zero", 0);
        issue(3'b110, 3'd3, 4'b0000, 1'b0, 0, 1, mk(4'b0011, 1'b1, 1, 3'b110, 0, 0));
        wait_done("reserved", 0);

        issue(3'b010, 3'd6, 4'b0000, 1'b1, 0, 0, nx);
        repeat (2) @(negedge clk);
        @(negedge clk);
        rst_n = 1'b0;
        @(negedge clk);
        chk("midrst_outputs", {18'd0, bus.set, bus.pl, bus.sl, bus.sr, bus.clear, bus.busy,
            bus.done, bus.err, bus.cmd_ready}, 32'd0);
        @(negedge clk);
        chk("midrst_hold", {29'd0, bus.cmd_ready, bus.done, bus.busy}, 32'd0);
        rst_n = 1'b1;
        @(negedge clk);
        chk("midrst_ready", {29'd0, bus.cmd_ready, bus.done, bus.busy}, 32'b100);
        for (int i = 0; i < 3; i++) begin
            @(negedge clk);
            chk("midrst_no_done", {31'd0, bus.done}, 32'd0);
        end

        issue(3'b100, 3'd0, 4'b0101, 1'b0, 0, 1, mk(4'b0101, 1'b0, 2, 3'b100, 1, 0));
        wait_done("load_post_reset", 0);
        chk("scoreboard_drained", sb.size(), 32'd0);

        $display("Result: errors=%0d of %0d checks", n_err, n_chk);
        $finish;
    end
endmodule
